// File: rtl/pc_fetch_sequencer.sv
// MIPS program counter and instruction fetch sequencer: PC selection, imem req/ready handshake, IF/ID delivery.
// Optional BRANCH_DELAY_SLOT_EN: branches and jumps let the delay-slot fetch complete before the PC is redirected.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    output logic [31:0] epc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        PRIO_NONE,
        PRIO_JMP,
        PRIO_BR,
        PRIO_EXC
    } prio_t;

    state_t      state, state_n;
    prio_t       pend_prio, prio_n, new_prio, eff_prio;
    logic [31:0] pc, pc_n;
    logic [31:0] target, target_n, new_target, raw_target, eff_target;
    logic        redirect_pending, pend_n;
    logic        imem_req_n, if_valid_n;
    logic [31:0] if_instr_n, if_pc_n, epc_n;
    logic        new_valid, take_new, eff_pending, eff_squash, eff_delayed;
    logic        fetch_done;

    assign imem_addr = pc;

    // Merge this cycle's redirect with any pending one; equal or higher priority overwrites.
    always_comb begin
        new_valid  = exc | br_taken | jmp;
        new_prio   = PRIO_NONE;
        raw_target = '0;
        if (exc) begin
            new_prio   = PRIO_EXC;
            raw_target = EXC_VECTOR;
        end else if (br_taken) begin
            new_prio   = PRIO_BR;
            raw_target = br_target;
        end else if (jmp) begin
            new_prio   = PRIO_JMP;
            raw_target = jmp_target;
        end
        new_target  = {raw_target[31:2], 2'b00};
        take_new    = new_valid && (!redirect_pending || (new_prio >= pend_prio));
        eff_target  = take_new ? new_target : target;
        eff_prio    = take_new ? new_prio : pend_prio;
        eff_pending = redirect_pending | new_valid;
`ifdef BRANCH_DELAY_SLOT_EN
        eff_squash  = eff_pending && (eff_prio == PRIO_EXC);
        eff_delayed = eff_pending && (eff_prio != PRIO_EXC);
`else
        eff_squash  = eff_pending;
        eff_delayed = 1'b0;
`endif
    end

    // Next-state and next-register logic; the outstanding request is never aborted.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        target_n   = target;
        prio_n     = pend_prio;
        pend_n     = redirect_pending;
        if_valid_n = if_valid;
        if_instr_n = if_instr;
        if_pc_n    = if_pc;
        epc_n      = epc;
        fetch_done = (state == REQ) && imem_ready;

        if (exc) begin
            epc_n = if_pc;
        end

        if (eff_squash && (state == REQ) && !imem_ready) begin
            pend_n     = 1'b1;
            target_n   = eff_target;
            prio_n     = eff_prio;
            if_valid_n = 1'b0;
        end else if (eff_squash) begin
            pc_n       = eff_target;
            pend_n     = 1'b0;
            prio_n     = PRIO_NONE;
            if_valid_n = 1'b0;
            state_n    = REQ;
        end else if (fetch_done) begin
            if_instr_n = imem_rdata;
            if_pc_n    = pc;
            if_valid_n = 1'b1;
            if (eff_delayed) begin
                pc_n   = eff_target;
                pend_n = 1'b0;
                prio_n = PRIO_NONE;
            end else begin
                pc_n = pc + STEP;
            end
            state_n = stall ? HOLD : REQ;
        end else begin
            if (eff_delayed) begin
                pend_n   = 1'b1;
                target_n = eff_target;
                prio_n   = eff_prio;
            end
            if (!stall) begin
                if_valid_n = 1'b0;
            end
            case (state)
                IDLE:    state_n = REQ;
                REQ:     state_n = REQ;
                HOLD:    state_n = stall ? HOLD : REQ;
                default: state_n = IDLE;
            endcase
        end

        imem_req_n = (state_n == REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_VECTOR;
            target           <= '0;
            pend_prio        <= PRIO_NONE;
            redirect_pending <= 1'b0;
            imem_req         <= 1'b0;
            if_valid         <= 1'b0;
            if_instr         <= '0;
            if_pc            <= '0;
            epc              <= '0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            target           <= target_n;
            pend_prio        <= prio_n;
            redirect_pending <= pend_n;
            imem_req         <= imem_req_n;
            if_valid         <= if_valid_n;
            if_instr         <= if_instr_n;
            if_pc            <= if_pc_n;
            epc              <= epc_n;
        end
    end

endmodule
